trigger_tcm_sched: RTL

Per-bunch-crossing trigger collector and readout scheduler for the FIT trigger datapath, running in the 320 MHz domain next to `trigger_wrapper`. It accumulates per-channel hits over one BC, which is eight `clk320` ticks delimited by the `mt_cou` phase counter. At each BC boundary it issues a TCM trigger request with summary time/amplitude words. It then drains the captured channel time/amplitude words one per handshake onto a shared readout port, using round-robin arbitration. A new BC's hits are dropped and counted when the previous BC has not finished draining.

---
 rtl/trigger_tcm_sched.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/trigger_tcm_sched.sv
// ============================================================================
// Module   : trigger_tcm_sched
// Brief    : Per-BC hit collector, TCM trigger request and round-robin readout
//            drain for the 320 MHz trigger datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

module trigger_tcm_sched #(
    parameter int NCH = 12,
    parameter int TW  = 12,
    parameter int AW  = 12,
    parameter int CW  = 4
) (
    input  logic              clk320,
    input  logic              rst_n,
    input  logic [2:0]        mt_cou,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH*TW-1:0] ch_time,
    input  logic [NCH*AW-1:0] ch_ampl,
    output logic              tcm_req,
    output logic [2:0]        tt,
    output logic [CW:0]       ta,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_ch,
    output logic [TW-1:0]     out_time,
    output logic [AW-1:0]     out_ampl,
    output logic              busy,
    output logic [15:0]       ovf_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    logic [TW-1:0]  w_ch_time  [NCH];
    logic [AW-1:0]  w_ch_ampl  [NCH];
    logic [NCH-1:0] r_cap_hit;
    logic [TW-1:0]  r_cap_time [NCH];
    logic [AW-1:0]  r_cap_ampl [NCH];
    logic [2:0]     r_cap_phase;
    logic [TW-1:0]  r_drn_time [NCH];
    logic [AW-1:0]  r_drn_ampl [NCH];
    logic [NCH-1:0] r_pend;
    logic [CW-1:0]  r_rr_ptr;
    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_tcm_req;
    logic [2:0]     r_tt;
    logic [CW:0]    r_ta;
    logic           r_busy;
    logic [15:0]    r_ovf_cnt;

    logic           w_snap;
    logic [NCH-1:0] w_mask;
    logic           w_accept;
    logic           w_drop;
    logic [2:0]     w_first_phase;
    logic [CW:0]    w_pop;
    logic [CW-1:0]  w_gnt_hi;
    logic [CW-1:0]  w_gnt_lo;
    logic           w_gnt_hi_found;
    logic [CW-1:0]  w_gnt;
    logic           w_hs;
    logic [NCH-1:0] w_pend_nxt;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
            assign w_ch_time[gi] = ch_time[gi*TW +: TW];
            assign w_ch_ampl[gi] = ch_ampl[gi*AW +: AW];
        end
    endgenerate

    // Strobes arriving on the snapshot cycle still belong to the closing BC.
    assign w_snap        = (mt_cou == 3'd7);
    assign w_mask        = r_cap_hit | ch_req;
    assign w_accept      = w_snap && (w_mask != '0) && !r_busy;
    assign w_drop        = w_snap && (w_mask != '0) && r_busy;
    assign w_first_phase = (r_cap_hit != '0) ? r_cap_phase : 3'd7;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NCH; i++) begin
            w_pop = w_pop + {{CW{1'b0}}, w_mask[i]};
        end
    end

    // Descending scan leaves the lowest matching index in each candidate.
    always_comb begin
        w_gnt_hi       = '0;
        w_gnt_lo       = '0;
        w_gnt_hi_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_gnt_lo = CW'(i);
                if (CW'(i) >= r_rr_ptr) begin
                    w_gnt_hi       = CW'(i);
                    w_gnt_hi_found = 1'b1;
                end
            end
        end
        w_gnt = w_gnt_hi_found ? w_gnt_hi : w_gnt_lo;
    end

    assign w_hs       = (r_state == ST_SERVE) && out_ready;
    assign w_pend_nxt = w_accept ? w_mask
                      : (w_hs ? (r_pend & ~(NCH'(1) << w_gnt)) : r_pend);

    always_ff @(posedge clk320 or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_hit   <= '0;
            r_cap_phase <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cap_time[i] <= '0;
                r_cap_ampl[i] <= '0;
            end
        end else if (w_snap) begin
            r_cap_hit   <= '0;
            r_cap_phase <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cap_time[i] <= '0;
                r_cap_ampl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_req[i] && !r_cap_hit[i]) begin
                    r_cap_hit[i]  <= 1'b1;
                    r_cap_time[i] <= w_ch_time[i];
                    r_cap_ampl[i] <= w_ch_ampl[i];
                end
            end
            if ((r_cap_hit == '0) && (ch_req != '0)) begin
                r_cap_phase <= mt_cou;
            end
        end
    end

    always_ff @(posedge clk320 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_drn_time[i] <= '0;
                r_drn_ampl[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < NCH; i++) begin
                if (w_mask[i]) begin
                    r_drn_time[i] <= r_cap_hit[i] ? r_cap_time[i] : w_ch_time[i];
                    r_drn_ampl[i] <= r_cap_hit[i] ? r_cap_ampl[i] : w_ch_ampl[i];
                end
            end
        end
    end

    always_ff @(posedge clk320 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_SERVE;
            ST_SERVE: if (w_pend_nxt == '0) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk320 or negedge rst_n) begin
        if (!rst_n) begin
            r_pend    <= '0;
            r_rr_ptr  <= '0;
            r_tcm_req <= 1'b0;
            r_tt      <= '0;
            r_ta      <= '0;
            r_busy    <= 1'b0;
            r_ovf_cnt <= '0;
        end else begin
            r_pend    <= w_pend_nxt;
            r_busy    <= (w_pend_nxt != '0);
            r_tcm_req <= w_accept;
            if (w_accept) begin
                r_tt <= w_first_phase;
                r_ta <= w_pop;
            end
            if (w_hs) begin
                r_rr_ptr <= (w_gnt == CW'(NCH - 1)) ? '0 : (w_gnt + CW'(1));
            end
            if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
        end
    end

    assign tcm_req   = r_tcm_req;
    assign tt        = r_tt;
    assign ta        = r_ta;
    assign busy      = r_busy;
    assign ovf_cnt   = r_ovf_cnt;
    assign out_valid = (r_state == ST_SERVE);
    assign out_ch    = out_valid ? w_gnt : '0;
    assign out_time  = out_valid ? r_drn_time[w_gnt] : '0;
    assign out_ampl  = out_valid ? r_drn_ampl[w_gnt] : '0;

endmodule

`default_nettype wire
